desalojo_ctrl: RTL and testbench

- Parametrised victim-selection and eviction controller for one N-way cache set, sitting between the cache tag/state array and the writeback path.
- Extends the fixed 4-way "all ways valid and clean" eviction detect:
  - handles fill into invalid ways, clean evictions and dirty evictions;
  - applies a round-robin fairness pointer;
  - for dirty victims, performs a writeback request/acknowledge handshake before reporting the victim.

---
 rtl/desalojo_pkg.sv | 14 +
 rtl/desalojo_rr_pick.sv | 26 ++
 rtl/desalojo_ctrl.sv | 130 +++++++++++++
 tb/tb_desalojo_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/desalojo_pkg.sv
// Shared types for the desalojo victim-selection controller.
package desalojo_pkg;

    typedef enum logic [1:0] {IDLE, SEL, WB, RESP} state_t;

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        CLEAN = 2'b01,
        DIRTY = 2'b10
    } kind_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/desalojo_rr_pick.sv
// Combinational search for the first set mask bit at or after start, wrapping modulo WAYS.
module desalojo_rr_pick #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  mask,
    input  logic [WAY_W-1:0] start,
    output logic [WAY_W-1:0] idx,
    output logic             found
);

    int pos;

    // Scan from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        idx   = '0;
        found = |mask;
        pos   = 0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            pos = int'(start) + i;
            if (pos >= WAYS) pos = pos - WAYS;
            if (mask[WAY_W'(pos)]) idx = WAY_W'(pos);
        end
    end

endmodule

// File: rtl/desalojo_ctrl.sv
// Victim selection / eviction controller for one N-way set with round-robin fairness.
// Optional hit counters stat_clean/stat_dirty are built when DESALOJO_STATS_EN is defined.
module desalojo_ctrl
    import desalojo_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WAYS-1:0]  valid_in,
    input  logic [WAYS-1:0]  dirty_in,
    output logic             wb_req,
    output logic [WAY_W-1:0] wb_way,
    input  logic             wb_ack,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WAY_W-1:0] resp_way,
    output logic [1:0]       resp_kind,
`ifdef DESALOJO_STATS_EN
    output logic [STAT_W-1:0] stat_clean,
    output logic [STAT_W-1:0] stat_dirty,
`endif
    output logic [WAY_W-1:0] rr_ptr_o
);

    state_t           state;
    logic [WAYS-1:0]  vq;
    logic [WAYS-1:0]  dq;
    logic [WAY_W-1:0] rr_ptr;
    logic [WAY_W-1:0] fill_idx;
    logic [WAY_W-1:0] clean_idx;
    logic             fill_found;
    logic             clean_found;

    function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
        if (int'(w) == WAYS - 1) return '0;
        return w + 1'b1;
    endfunction

    desalojo_rr_pick #(.WAYS(WAYS)) u_fill_pick (
        .mask  (~vq),
        .start ('0),
        .idx   (fill_idx),
        .found (fill_found)
    );

    desalojo_rr_pick #(.WAYS(WAYS)) u_clean_pick (
        .mask  (~dq),
        .start (rr_ptr),
        .idx   (clean_idx),
        .found (clean_found)
    );

    assign rr_ptr_o = rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            vq         <= '0;
            dq         <= '0;
            req_ready  <= 1'b0;
            wb_req     <= 1'b0;
            wb_way     <= '0;
            resp_valid <= 1'b0;
            resp_way   <= '0;
            resp_kind  <= FILL;
`ifdef DESALOJO_STATS_EN
            stat_clean <= '0;
            stat_dirty <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        vq        <= valid_in;
                        dq        <= dirty_in & valid_in;
                        req_ready <= 1'b0;
                        state     <= SEL;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SEL: begin
                    if (fill_found) begin
                        resp_way   <= fill_idx;
                        resp_kind  <= FILL;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (clean_found) begin
                        resp_way   <= clean_idx;
                        resp_kind  <= CLEAN;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wb_way    <= rr_ptr;
                        wb_req    <= 1'b1;
                        resp_way  <= rr_ptr;
                        resp_kind <= DIRTY;
                        state     <= WB;
                    end
                end
                WB: begin
                    if (wb_ack) begin
                        wb_req     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                        if (resp_kind != FILL) rr_ptr <= next_way(resp_way);
`ifdef DESALOJO_STATS_EN
                        if (resp_kind == CLEAN && stat_clean != '1) stat_clean <= stat_clean + 1'b1;
                        if (resp_kind == DIRTY && stat_dirty != '1) stat_dirty <= stat_dirty + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_desalojo_ctrl.sv
// Self-checking bench for desalojo_ctrl (WAYS=4): directed table, hand sequences, randomized vs. model.
module tb_desalojo_ctrl;
    import desalojo_pkg::*;

    localparam int WAYS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] valid_in = '0;
    logic [3:0] dirty_in = '0;
    logic       wb_req;
    logic [1:0] wb_way;
    logic       wb_ack = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [1:0] resp_way;
    logic [1:0] resp_kind;
    logic [1:0] rr_ptr_o;
`ifdef DESALOJO_STATS_EN
    logic [15:0] stat_clean;
    logic [15:0] stat_dirty;
`endif

    int checks = 0;
    int failures = 0;
    int mrr = 0;
    int n_clean = 0;
    int n_dirty = 0;

    always #5 clk = ~clk;

    desalojo_ctrl #(.WAYS(WAYS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .valid_in   (valid_in),
        .dirty_in   (dirty_in),
        .wb_req     (wb_req),
        .wb_way     (wb_way),
        .wb_ack     (wb_ack),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_way   (resp_way),
        .resp_kind  (resp_kind),
`ifdef DESALOJO_STATS_EN
        .stat_clean (stat_clean),
        .stat_dirty (stat_dirty),
`endif
        .rr_ptr_o   (rr_ptr_o)
    );

    typedef struct {
        logic [3:0] v;
        logic [3:0] d;
        int         wbdly;
        int         rdly;
        int         kind;
        int         way;
        int         rr;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        wb_ack = 1'b0;
        resp_ready = 1'b0;
        tick();
        rst = 1'b0;
        mrr = 0;
        n_clean = 0;
        n_dirty = 0;
    endtask

    // Reference: fill lowest invalid, else first clean from rr with wrap, else dirty at rr.
    function automatic void model(input logic [3:0] v, input logic [3:0] d, input int rr,
                                  output int kind, output int way, output int rr_next);
        kind = -1;
        way  = 0;
        for (int i = 0; i < WAYS; i++)
            if (!v[i] && kind < 0) begin kind = 0; way = i; end
        for (int k = 0; k < WAYS; k++) begin
            int j;
            j = (rr + k) % WAYS;
            if (!d[j] && kind < 0) begin kind = 1; way = j; end
        end
        if (kind < 0) begin kind = 2; way = rr; end
        rr_next = (kind == 0) ? rr : (way + 1) % WAYS;
    endfunction

    task automatic run_txn(input logic [3:0] v, input logic [3:0] d, input int wbdly, input int rdly,
                           input int ekind, input int eway, input int err);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            do_reset();
            tick();
            return;
        end
        req_valid = 1'b1;
        valid_in  = v;
        dirty_in  = d;
        tick();
        req_valid = 1'b0;
        valid_in  = 4'($urandom);
        dirty_in  = 4'($urandom);
        chk("sel_quiet", 32'({req_ready, wb_req, resp_valid}), 32'd0);
        tick();
        if (ekind == 2) begin
            for (int i = 0; i <= wbdly; i++) begin
                chk("wb_req", 32'(wb_req), 32'd1);
                chk("wb_way", 32'(wb_way), 32'(eway));
                chk("wb_no_resp", 32'(resp_valid), 32'd0);
                wb_ack = (i == wbdly);
                tick();
            end
            wb_ack = 1'b0;
            chk("wb_req_drop", 32'(wb_req), 32'd0);
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_way", 32'(resp_way), 32'(eway));
        chk("resp_kind", 32'(resp_kind), 32'(ekind));
        for (int i = 0; i < rdly; i++) begin
            wb_ack = 1'($urandom);
            tick();
            chk("resp_hold", 32'({resp_valid, req_ready, wb_req, resp_kind, resp_way}),
                32'({1'b1, 1'b0, 1'b0, 2'(ekind), 2'(eway)}));
        end
        wb_ack = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
        chk("rr_ptr", 32'(rr_ptr_o), 32'(err));
        if (ekind == 1) n_clean++;
        if (ekind == 2) n_dirty++;
        mrr = err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, w, r;
        tbl[0] = '{4'b1011, 4'b1111, 0, 0, 0, 2, 0};
        tbl[1] = '{4'b1111, 4'b0000, 0, 1, 1, 0, 1};
        tbl[2] = '{4'b1111, 4'b0000, 0, 0, 1, 1, 2};
        tbl[3] = '{4'b1111, 4'b1101, 0, 2, 1, 1, 2};
        tbl[4] = '{4'b1111, 4'b1111, 1, 0, 2, 2, 3};
        tbl[5] = '{4'b1111, 4'b1111, 5, 4, 2, 3, 0};
        tbl[6] = '{4'b0111, 4'b1000, 0, 0, 0, 3, 0};
        tbl[7] = '{4'b1111, 4'b0111, 0, 0, 1, 3, 0};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_outputs", 32'({req_ready, wb_req, resp_valid, resp_way, resp_kind, wb_way, rr_ptr_o}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].v, tbl[i].d, tbl[i].wbdly, tbl[i].rdly, tbl[i].kind, tbl[i].way, tbl[i].rr);

        // Reset while a writeback is outstanding.
        run_txn(4'b1111, 4'b0000, 0, 0, 1, 0, 1);
        req_valid = 1'b1;
        valid_in  = 4'b1111;
        dirty_in  = 4'b1111;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_wb_req", 32'(wb_req), 32'd1);
        chk("mid_wb_way", 32'(wb_way), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst", 32'({wb_req, resp_valid, req_ready, rr_ptr_o}), 32'd0);
        rst = 1'b0;
        mrr = 0;
        n_clean = 0;
        n_dirty = 0;
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [3:0] v, d;
            v = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            d = 4'($urandom);
            model(v, d, mrr, k, w, r);
            run_txn(v, d, $urandom_range(0, 3), $urandom_range(0, 3), k, w, r);
        end

`ifdef DESALOJO_STATS_EN
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            model(4'b1111, 4'b0000, mrr, k, w, r);
            run_txn(4'b1111, 4'b0000, 0, 0, k, w, r);
        end
        for (int i = 0; i < 2; i++) begin
            model(4'b1111, 4'b1111, mrr, k, w, r);
            run_txn(4'b1111, 4'b1111, 1, 0, k, w, r);
        end
        chk("stat_clean", 32'(stat_clean), 32'd3);
        chk("stat_dirty", 32'(stat_dirty), 32'd2);
        force dut.stat_clean = 16'hFFFF;
        tick();
        release dut.stat_clean;
        model(4'b1111, 4'b0000, mrr, k, w, r);
        run_txn(4'b1111, 4'b0000, 0, 0, k, w, r);
        chk("stat_clean_sat", 32'(stat_clean), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
